ex_operand_stage: RTL

ID/EX pipeline register and operand-select front end for the 16-bit execute stage.
- Captures decoded instruction fields from decode.
- Generates the 4-bit ALU control code.
- Resolves register operands through EX/MEM and MEM/WB forwarding, then presents A, B and control directly to the ALU inputs.
- Also detects load-use hazards and requests a decode stall.

---
 rtl/ex_operand_stage.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand front end: decodes control, forwards from
// EX/MEM and MEM/WB, and flags load-use hazards against the instruction in decode.
module ex_operand_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic          i_id_valid,
    input  logic [3:0]    i_id_opcode,
    input  logic [2:0]    i_id_funct,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic [RW-1:0] i_id_rd,
    input  logic [DW-1:0] i_id_rs_data,
    input  logic [DW-1:0] i_id_rt_data,
    input  logic [5:0]    i_id_imm,
    input  logic          i_exmem_regwrite,
    input  logic [RW-1:0] i_exmem_rd,
    input  logic [DW-1:0] i_exmem_result,
    input  logic          i_memwb_regwrite,
    input  logic [RW-1:0] i_memwb_rd,
    input  logic [DW-1:0] i_memwb_result,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output logic [3:0]    o_alu_ctrl,
    output logic          o_ex_valid,
    output logic [RW-1:0] o_ex_rd,
    output logic          o_ex_regwrite,
    output logic          o_ex_memread,
    output logic          o_ex_memwrite,
    output logic [DW-1:0] o_ex_store_data,
    output logic          o_ex_branch,
    output logic          o_load_use_stall
);

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAddi  = 4'b0001;
    localparam logic [3:0] OpAndi  = 4'b0010;
    localparam logic [3:0] OpOri   = 4'b0011;
    localparam logic [3:0] OpXori  = 4'b0100;
    localparam logic [3:0] OpSlti  = 4'b0101;
    localparam logic [3:0] OpLw    = 4'b0110;
    localparam logic [3:0] OpSw    = 4'b0111;
    localparam logic [3:0] OpBeq   = 4'b1000;

    // Decode-side signals
    logic          w_dec_valid;
    logic [3:0]    w_dec_ctrl;
    logic [RW-1:0] w_dec_rd;
    logic          w_dec_regwrite;
    logic          w_dec_memread;
    logic          w_dec_memwrite;
    logic          w_dec_branch;
    logic          w_dec_use_imm;
    logic          w_dec_imm_sext;
    logic [DW-1:0] w_dec_imm;
    logic          w_cap_valid;
    logic          w_id_uses_rt;

    // ID/EX register
    logic          r_valid;
    logic [3:0]    r_alu_ctrl;
    logic [RW-1:0] r_rd;
    logic          r_regwrite;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_branch;
    logic          r_use_imm;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;

    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    always_comb begin
        w_dec_valid    = 1'b1;
        w_dec_ctrl     = 4'b0000;
        w_dec_rd       = i_id_rt;
        w_dec_regwrite = 1'b1;
        w_dec_memread  = 1'b0;
        w_dec_memwrite = 1'b0;
        w_dec_branch   = 1'b0;
        w_dec_use_imm  = 1'b1;
        w_dec_imm_sext = 1'b1;
        case (i_id_opcode)
            OpRtype: begin
                w_dec_ctrl    = (i_id_funct == 3'b111) ? 4'b0000 : {1'b0, i_id_funct};
                w_dec_rd      = i_id_rd;
                w_dec_use_imm = 1'b0;
            end
            OpAddi: w_dec_ctrl = 4'b0000;
            OpAndi: begin
                w_dec_ctrl     = 4'b0010;
                w_dec_imm_sext = 1'b0;
            end
            OpOri: begin
                w_dec_ctrl     = 4'b0011;
                w_dec_imm_sext = 1'b0;
            end
            OpXori: begin
                w_dec_ctrl     = 4'b0100;
                w_dec_imm_sext = 1'b0;
            end
            OpSlti: w_dec_ctrl = 4'b0110;
            OpLw:   w_dec_memread = 1'b1;
            OpSw: begin
                w_dec_memwrite = 1'b1;
                w_dec_regwrite = 1'b0;
            end
            OpBeq: begin
                w_dec_ctrl     = 4'b0001;
                w_dec_branch   = 1'b1;
                w_dec_regwrite = 1'b0;
                w_dec_use_imm  = 1'b0;
            end
            default: w_dec_valid = 1'b0;
        endcase
        // r0 is hardwired zero, so a write to it is dropped at capture
        if (w_dec_rd == '0) begin
            w_dec_regwrite = 1'b0;
        end
    end

    assign w_dec_imm = w_dec_imm_sext ? {{(DW-6){i_id_imm[5]}}, i_id_imm}
                                      : {{(DW-6){1'b0}}, i_id_imm};
    assign w_cap_valid = i_id_valid & w_dec_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || (!i_stall && !w_cap_valid)) begin
            r_valid    <= 1'b0;
            r_alu_ctrl <= 4'b0000;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_use_imm  <= 1'b0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
        end else if (!i_stall) begin
            r_valid    <= 1'b1;
            r_alu_ctrl <= w_dec_ctrl;
            r_rd       <= w_dec_rd;
            r_regwrite <= w_dec_regwrite;
            r_memread  <= w_dec_memread;
            r_memwrite <= w_dec_memwrite;
            r_branch   <= w_dec_branch;
            r_use_imm  <= w_dec_use_imm;
            r_imm      <= w_dec_imm;
            r_rs       <= i_id_rs;
            r_rt       <= i_id_rt;
            r_rs_data  <= i_id_rs_data;
            r_rt_data  <= i_id_rt_data;
        end
    end

    // Youngest producer wins; r0 never forwards and always reads zero
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] rf_val,
        input logic          ex_we,
        input logic [RW-1:0] ex_rd,
        input logic [DW-1:0] ex_val,
        input logic          wb_we,
        input logic [RW-1:0] wb_rd,
        input logic [DW-1:0] wb_val
    );
        logic [DW-1:0] v;
        if (src == '0) begin
            v = '0;
        end else if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
            v = ex_val;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            v = wb_val;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    always_comb begin
        w_fwd_rs = fwd_sel(r_rs, r_rs_data, i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                           i_memwb_regwrite, i_memwb_rd, i_memwb_result);
        w_fwd_rt = fwd_sel(r_rt, r_rt_data, i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                           i_memwb_regwrite, i_memwb_rd, i_memwb_result);
    end

    assign w_id_uses_rt = (i_id_opcode == OpRtype) || (i_id_opcode == OpSw) ||
                          (i_id_opcode == OpBeq);

    assign o_load_use_stall = r_valid && r_memread && (r_rd != '0) && i_id_valid &&
                              ((r_rd == i_id_rs) || (w_id_uses_rt && (r_rd == i_id_rt)));

    assign o_alu_a         = w_fwd_rs;
    assign o_alu_b         = r_use_imm ? r_imm : w_fwd_rt;
    assign o_alu_ctrl      = r_alu_ctrl;
    assign o_ex_valid      = r_valid;
    assign o_ex_rd         = r_rd;
    assign o_ex_regwrite   = r_regwrite;
    assign o_ex_memread    = r_memread;
    assign o_ex_memwrite   = r_memwrite;
    assign o_ex_store_data = w_fwd_rt;
    assign o_ex_branch     = r_branch;

endmodule
